// File: rtl/bit_serializer_if.sv
// Word-in / bit-out handshake bundle for bit_serializer.
// The producer side is master; the serializer side is slave.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x;
    logic             x_valid;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, x, x_valid, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, x, x_valid, busy
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out on x.
// A one-word holding register lets consecutive words stream without an idle gap.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    bit_serializer_if.slave   bus
);
    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    logic xfer;
    logic last;
    logic out_bit;

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        if (MSB_FIRST)
            return {v[WIDTH-2:0], 1'b0};
        else
            return {1'b0, v[WIDTH-1:1]};
    endfunction

    assign xfer    = bus.din_valid & ~hold_full_q;
    assign last    = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign out_bit = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    sh_d    = bus.din;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!last) begin
                    sh_d  = advance(sh_q);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (xfer) begin
                        hold_d      = bus.din;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // Held word takes priority; din_ready is low this cycle so no transfer competes.
                    sh_d        = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (xfer) begin
                    sh_d  = bus.din;
                    cnt_d = '0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign bus.din_ready = ~hold_full_q;
    assign bus.x_valid   = (state_q == SHIFT);
    assign bus.x         = (state_q == SHIFT) & out_bit;
    assign bus.busy      = (state_q == SHIFT) | hold_full_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Randomized and directed bench for bit_serializer; two instances (MSB-first and LSB-first)
// share one stimulus and are checked against a pending-bit queue model.
module tb_bit_serializer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         din_valid;

    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(W)) bus0 ();
    bit_serializer_if #(.WIDTH(W)) bus1 ();

    assign bus0.din       = din;
    assign bus0.din_valid = din_valid;
    assign bus1.din       = din;
    assign bus1.din_valid = din_valid;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    // Model: bits still owed on x, in emission order. The head is the bit shown this cycle.
    bit q_msb[$];
    bit q_lsb[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] cap0, cap1;
    int          capn0, capn1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_outputs();
        chk("rdy_msb",  {31'd0, bus0.din_ready}, {31'd0, q_msb.size() <= W});
        chk("vld_msb",  {31'd0, bus0.x_valid},   {31'd0, q_msb.size() != 0});
        chk("busy_msb", {31'd0, bus0.busy},      {31'd0, q_msb.size() != 0});
        chk("x_msb",    {31'd0, bus0.x},         {31'd0, (q_msb.size() != 0) ? q_msb[0] : 1'b0});
        chk("rdy_lsb",  {31'd0, bus1.din_ready}, {31'd0, q_lsb.size() <= W});
        chk("vld_lsb",  {31'd0, bus1.x_valid},   {31'd0, q_lsb.size() != 0});
        chk("busy_lsb", {31'd0, bus1.busy},      {31'd0, q_lsb.size() != 0});
        chk("x_lsb",    {31'd0, bus1.x},         {31'd0, (q_lsb.size() != 0) ? q_lsb[0] : 1'b0});
        if (bus0.x_valid) begin cap0 = {cap0[62:0], bus0.x}; capn0++; end
        if (bus1.x_valid) begin cap1 = {cap1[62:0], bus1.x}; capn1++; end
    endtask

    // Called just after a falling edge: drive inputs, advance the model across the next
    // rising edge, then check outputs at the following falling edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, output bit acc);
        din_valid = v;
        din       = d;
        acc       = v && (q_msb.size() <= W);
        if (q_msb.size() != 0) void'(q_msb.pop_front());
        if (q_lsb.size() != 0) void'(q_lsb.pop_front());
        if (acc) begin
            for (int i = 0; i < W; i++) begin
                q_msb.push_back(d[W-1-i]);
                q_lsb.push_back(d[i]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, a);
    endtask

    task automatic send(input logic [W-1:0] d);
        bit a;
        a = 1'b0;
        for (int i = 0; i < 4 * W && !a; i++) cycle(1'b1, d, a);
        if (!a) chk("send_timeout", 32'd0, 32'd1);
        din_valid = 1'b0;
    endtask

    task automatic clear_caps();
        cap0 = '0; cap1 = '0; capn0 = 0; capn1 = 0;
    endtask

    initial begin
        reset     = 1'b1;
        din_valid = 1'b0;
        din       = '0;
        clear_caps();
        repeat (2) @(negedge clk);
        chk("rst_x",    {31'd0, bus0.x},         32'd0);
        chk("rst_vld",  {31'd0, bus0.x_valid},   32'd0);
        chk("rst_rdy",  {31'd0, bus0.din_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus0.busy},      32'd0);
        reset = 1'b0;
        check_outputs();

        // Single word
        clear_caps();
        send(8'hA5);
        idle(10);
        chk("a5_bits", cap0[31:0], 32'h0000_00A5);
        chk("a5_cnt",  capn0, 8);

        // Back-to-back with valid held high
        clear_caps();
        send(8'hA0);
        send(8'h0A);
        idle(20);
        chk("b2b_bits", cap0[31:0], 32'h0000_A00A);
        chk("b2b_cnt",  capn0, 16);

        // Backpressure: three words offered continuously
        clear_caps();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        idle(30);
        chk("bp_bits", cap0[31:0], 32'h0011_2233);
        chk("bp_cnt",  capn0, 24);

        // LSB first: 05 -> 1,0,1,0,0,0,0,0
        clear_caps();
        send(8'h05);
        idle(10);
        chk("lsb_bits", cap1[31:0], 32'h0000_00A0);

        // Words separated by idle cycles
        clear_caps();
        send(8'hC3);
        idle(W - 1 + 3);
        send(8'h3C);
        idle(10);
        chk("gap_bits", cap0[31:0], 32'h0000_C33C);

        // Reset mid-word: FF shifting, F0 in hold, reset during bit 3
        send(8'hFF);
        send(8'hF0);
        idle(2);
        #2 reset = 1'b1;
        #1;
        chk("mid_x",    {31'd0, bus0.x},         32'd0);
        chk("mid_vld",  {31'd0, bus0.x_valid},   32'd0);
        chk("mid_rdy",  {31'd0, bus0.din_ready}, 32'd1);
        chk("mid_busy", {31'd0, bus0.busy},      32'd0);
        chk("mid_vld1", {31'd0, bus1.x_valid},   32'd0);
        q_msb.delete();
        q_lsb.delete();
        @(negedge clk);
        reset = 1'b0;
        clear_caps();
        idle(12);
        chk("post_rst_quiet", capn0, 0);
        send(8'h5A);
        idle(10);
        chk("post_rst_bits", cap0[31:0], 32'h0000_005A);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit a;
            cycle(($urandom_range(0, 3) != 0), W'($urandom), a);
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
